// File: rtl/mem_sequencer.sv
// Load/store sequencer between the core and a word-wide memory port.
// Subword stores use read-modify-write; load results are lane-extracted and extended.
module mem_sequencer (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        re_in,
  input  logic        we_in,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [29:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_rdata_in,
  output logic        stall_out,
  output logic [31:0] rdata_out,
  output logic        done_out,
  output logic        misalign_out
);

  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wword_q, wword_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        st_q, st_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req;
  logic        bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign req = re_in | we_in;
  assign bad = (re_in & we_in)
             | (size_in == 2'b10)
             | ((size_in == 2'b01) & addr_in[0])
             | ((size_in == 2'b11) & (|addr_in[1:0]));

  assign lane_b = mem_rdata_in[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = mem_rdata_in[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = mem_rdata_in;
    merged   = mem_rdata_in;
    unique case (size_q)
      2'b00: begin
        load_val = {{24{~uns_q & lane_b[7]}}, lane_b};
        merged[{addr_q[1:0], 3'b000} +: 8] = wword_q[7:0];
      end
      2'b01: begin
        load_val = {{16{~uns_q & lane_h[15]}}, lane_h};
        merged[{addr_q[1], 4'b0000} +: 16] = wword_q[15:0];
      end
      default: begin
        load_val = mem_rdata_in;
        merged   = wword_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wword_d = wword_q;
    size_d  = size_q;
    uns_d   = uns_q;
    st_d    = st_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr_in;
          wword_d = wdata_in;
          size_d  = size_in;
          uns_d   = unsigned_in;
          st_d    = we_in;
          if (bad)
            state_d = ERR;
          else if (re_in || size_in != 2'b11)
            state_d = RD;
          else
            state_d = WR;
        end
      end
      RD: begin
        if (mem_ready_in) begin
          if (st_q) begin
            wword_d = merged;
            state_d = WR;
          end else begin
            rdata_d = load_val;
            state_d = DONE;
          end
        end
      end
      WR: begin
        if (mem_ready_in)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wword_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      st_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wword_q <= wword_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      st_q    <= st_d;
      rdata_q <= rdata_d;
    end
  end

  // stall is combinational so the PC freezes in the same cycle a request appears
  assign mem_req_out   = (state_q == RD) || (state_q == WR);
  assign mem_we_out    = (state_q == WR);
  assign mem_addr_out  = addr_q[31:2];
  assign mem_wdata_out = wword_q;
  assign stall_out     = ((state_q == IDLE) & req & ~rst_in) | mem_req_out;
  assign rdata_out     = rdata_q;
  assign done_out      = (state_q == DONE);
  assign misalign_out  = (state_q == ERR);

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk_in  input  1  clock; all state updates on the rising edge.
REQ-003 rst_in  input  1  asynchronous active-high reset.
REQ-004 re_in  input  1  load request from control.
REQ-005 we_in  input  1  store request from control.
REQ-006 size_in  input  2  access size: 00 byte, 01 halfword, 11 word; 10 is illegal.
REQ-007 unsigned_in  input  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-008 addr_in  input  32  byte address from the ALU.
REQ-009 wdata_in  input  32  store data, right-justified.
REQ-010 mem_req_out  output  1  memory request valid.
REQ-011 mem_we_out  output  1  memory request is a write.
REQ-012 mem_addr_out  output  30  word address, equal to the latched addr[31:2].
REQ-013 mem_wdata_out  output  32  full-word write data.
REQ-014 mem_ready_in  input  1  memory completes the current request this cycle.
REQ-015 mem_rdata_in  input  32  read word, valid when mem_ready_in=1.
REQ-016 stall_out  output  1  holds the PC and pipeline; the core ANDs it into pc_enable.
REQ-017 rdata_out  output  32  extended load result.
REQ-018 done_out  output  1  one-cycle pulse when the access completes.
REQ-019 misalign_out  output  1  one-cycle pulse when an access is rejected.

Function
REQ-020 The FSM states SHALL be IDLE, RD, WR, DONE and ERR, with registered state.
REQ-021 In IDLE with re_in or we_in set, the block SHALL latch addr_in, wdata_in, size_in, unsigned_in and the access type.
REQ-022 An access SHALL be rejected (IDLE->ERR) for any of: re_in=we_in=1; size 10; halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-023 A rejected access SHALL NOT issue a memory request.
REQ-024 The transitions SHALL be:
- load: IDLE->RD->DONE.
- word store: IDLE->WR->DONE.
- byte or halfword store: IDLE->RD->WR->DONE (read-modify-write).
REQ-025 The block SHALL remain in RD or WR until mem_req_out=1 and mem_ready_in=1 at a clock edge, with no maximum wait.
REQ-026 mem_req_out SHALL be 1 only in RD and WR; mem_we_out SHALL be 1 only in WR.
REQ-027 mem_addr_out and mem_wdata_out SHALL be stable for the whole request.
REQ-028 stall_out SHALL be combinational:
- 1 in IDLE when re_in|we_in.
- 1 in RD and WR.
- 0 in DONE, ERR and idle IDLE.
REQ-029 DONE and ERR SHALL each last exactly one cycle, then return to IDLE; re_in and we_in SHALL be ignored in DONE and ERR.
REQ-030 Byte lanes SHALL be little-endian: byte lane = addr[1:0] at bits [8*lane+7:8*lane]; halfword lane = addr[1] at bits [16*addr[1]+15:16*addr[1]].
REQ-031 Load extraction SHALL select the lane from the mem_rdata_in word captured at the RD handshake, then zero- or sign-extend it per unsigned_in.
REQ-032 rdata_out SHALL be registered, valid from DONE onward, and held until the next load completes.
REQ-033 For a subword store, the WR word SHALL be the RD word with only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
REQ-034 For a word store, the WR word SHALL be wdata in full.
REQ-035 done_out SHALL be 1 only in DONE; misalign_out SHALL be 1 only in ERR.
REQ-036 Minimum latency SHALL be: load and word store 2 cycles from acceptance to DONE with zero wait; subword store 3 cycles.
REQ-037 mem_ready_in SHALL be ignored in IDLE, DONE and ERR.

Reset
REQ-038 While rst_in=1, including mid-access, the block SHALL force: state IDLE, mem_req_out=0, mem_we_out=0, stall_out=0, done_out=0, misalign_out=0, rdata_out=0, all latches 0.
REQ-039 An access interrupted by reset SHALL be abandoned and not resumed; the first request after reset deasserts is accepted normally.

Verification
REQ-040 Signed byte load: lb, addr=0x102, mem_rdata=0x11A2_3344, ready on the first RD cycle -> rdata_out=0xFFFFFFA2 in DONE, done_out pulses, stall_out=1 for exactly 2 cycles.
REQ-041 Unsigned halfword load: lhu, addr=0x202, mem_rdata=0x8001_1234, 3 wait cycles -> rdata_out=0x00008001, stall_out high for 5 cycles.
REQ-042 Byte store: sb, addr=0x301, wdata=0xAB, RD returns 0x1122_3344 -> WR with mem_we_out=1, mem_wdata_out=0x1122_AB44, mem_addr_out=0xC0.
REQ-043 Misaligned word store: sw, addr=0x0006 -> ERR for one cycle, misalign_out=1, mem_req_out stays 0, stall_out=0.
REQ-044 Both requests: re_in=we_in=1 -> ERR with misalign_out=1, no memory request.
REQ-045 Reset mid-store: rst_in asserted while in WR with mem_ready_in=0 -> mem_req_out=0 immediately, state IDLE; a subsequent lw, addr=0x10, completes normally.
